// File: rtl/matmul_seq_engine_pkg.sv
// matmul_pkg: shared types and helpers for the sequential matrix multiplier.
//   state_t    : controller states
//   acc_width  : accumulator width that cannot overflow for a K-term dot product
//   sat_trunc  : maps an accumulator value to the output word width
// Build option: define MATMUL_SAT_EN to saturate results to the signed
// output range; otherwise results wrap to their low bits.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    MAC,
    WRITE,
    DONE
  } state_t;

  // Working widths for sat_trunc. Callers widen the accumulator into
  // SAT_AMAX bits and keep the low data_w bits of the result.
  localparam int SAT_DMAX = 64;
  localparam int SAT_AMAX = 160;

  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k) + 1;
  endfunction

  function automatic logic [SAT_DMAX-1:0] sat_trunc(input logic signed [SAT_AMAX-1:0] acc,
                                                    input int data_w);
    logic [SAT_DMAX-1:0] r;
`ifdef MATMUL_SAT_EN
    logic signed [SAT_AMAX-1:0] one;
    logic signed [SAT_AMAX-1:0] hi;
    logic signed [SAT_AMAX-1:0] lo;
    one = SAT_AMAX'(1);
    hi  = (one <<< (data_w - 1)) - one;
    lo  = -(one <<< (data_w - 1));
    if (acc > hi) begin
      r = hi[SAT_DMAX-1:0];
    end else if (acc < lo) begin
      r = lo[SAT_DMAX-1:0];
    end else begin
      r = acc[SAT_DMAX-1:0];
    end
`else
    r = acc[SAT_DMAX-1:0];
`endif
    return r;
  endfunction

endpackage

// File: rtl/matmul_seq_engine_if.sv
// matmul_seq_engine_if: control handshake plus shared-memory ports of the
// matrix multiplier, bundled as one interface.
//   start, a_base, b_base, c_base : request and operand/result base addresses
//   busy, done                    : operation status
//   mem_rd_en/addr, mem_rd_data   : read port (data returns one cycle after en)
//   mem_wr_en/addr/data           : write port
// master: the MCU/memory side; slave: the engine.
interface matmul_seq_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] c_base;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (
    output start, a_base, b_base, c_base, mem_rd_data,
    input  busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  start, a_base, b_base, c_base, mem_rd_data,
    output busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/matmul_seq_engine_mac.sv
// matmul_mac: single signed multiply-accumulate unit.
//   clk, reset : clock, synchronous active-high reset (clears acc)
//   clear      : zero the accumulator at the next edge
//   en         : add a*b into the accumulator at the next edge
//   a, b       : signed operands
//   acc        : registered signed accumulator, ACC_W bits
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K      = 2,
  parameter int ACC_W  = acc_width(DATA_W, K)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  (* multstyle = "dsp" *) logic signed [2*DATA_W-1:0] prod;

  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/matmul_seq_engine.sv
// matmul_seq_engine: sequential signed C = A x B over a shared word memory.
//   clk, reset : clock, synchronous active-high reset (aborts any operation)
//   bus        : matmul_seq_engine_if.slave -- start/busy/done handshake,
//                one read port and one write port
// Matrices are row-major: A[i][k] at a_base+i*K+k, B[k][j] at b_base+k*N+j,
// C[i][j] at c_base+i*N+j, all modulo 2^ADDR_W. Each C element takes K
// fetch/fetch/accumulate triples and one write; one MAC unit is reused.
// Build option: MATMUL_SAT_EN saturates results instead of wrapping.
module matmul_seq_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2,
  parameter int ACC_W  = acc_width(DATA_W, K)
) (
  input  logic clk,
  input  logic reset,
  matmul_seq_engine_if.slave bus
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [ADDR_W-1:0] c_base_q;
  logic [IW-1:0]     i_q;
  logic [JW-1:0]     j_q;
  logic [KW-1:0]     k_q;

  logic signed [DATA_W-1:0] a_reg;
  logic signed [ACC_W-1:0]  acc;

  logic mac_clear;
  logic mac_en;
  logic last_i;
  logic last_j;
  logic last_k;
  logic accept;

  logic [ADDR_W-1:0]   a_addr;
  logic [ADDR_W-1:0]   b_addr;
  logic [ADDR_W-1:0]   c_addr;
  logic [SAT_DMAX-1:0] res_wide;
  logic [DATA_W-1:0]   result;
  logic                unused_res_hi;

  assign last_i = (i_q == IW'(M - 1));
  assign last_j = (j_q == JW'(N - 1));
  assign last_k = (k_q == KW'(K - 1));
  assign accept = (state_q == IDLE) && bus.start;

  assign a_addr = a_base_q + ADDR_W'(i_q) * ADDR_W'(K) + ADDR_W'(k_q);
  assign b_addr = b_base_q + ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q);
  assign c_addr = c_base_q + ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q);

  assign res_wide      = sat_trunc(SAT_AMAX'(acc), DATA_W);
  assign result        = res_wide[DATA_W-1:0];
  assign unused_res_hi = ^res_wide[SAT_DMAX-1:DATA_W];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; every output is zero unless a state drives it
  always_comb begin
    state_d         = state_q;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    mac_clear       = 1'b0;
    mac_en          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mac_clear = 1'b1;
          state_d   = FETCH_A;
        end
      end
      FETCH_A: begin
        bus.busy        = 1'b1;
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = a_addr;
        state_d         = FETCH_B;
      end
      FETCH_B: begin
        bus.busy        = 1'b1;
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = b_addr;
        state_d         = MAC;
      end
      MAC: begin
        bus.busy = 1'b1;
        mac_en   = 1'b1;
        state_d  = last_k ? WRITE : FETCH_A;
      end
      WRITE: begin
        bus.busy        = 1'b1;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = c_addr;
        bus.mem_wr_data = result;
        mac_clear       = 1'b1;
        state_d         = (last_i && last_j) ? DONE : FETCH_A;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Element and term counters: k runs fastest, then j, then i
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
          end
        end
        MAC: begin
          if (!last_k) begin
            k_q <= k_q + 1'b1;
          end
        end
        WRITE: begin
          k_q <= '0;
          if (last_j) begin
            j_q <= '0;
            i_q <= last_i ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture: bases on accept, A element one cycle after its read
  always_ff @(posedge clk) begin
    if (accept) begin
      a_base_q <= bus.a_base;
      b_base_q <= bus.b_base;
      c_base_q <= bus.c_base;
    end
    if (state_q == FETCH_B) begin
      a_reg <= $signed(bus.mem_rd_data);
    end
  end

  // B element arrives during MAC and is multiplied straight off the bus
  matmul_mac #(
    .DATA_W (DATA_W),
    .K      (K),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (a_reg),
    .b     ($signed(bus.mem_rd_data)),
    .acc   (acc)
  );

endmodule
